// File: rtl/lock_arbiter_pkg.sv
// lock_arbiter_pkg: shared state type and round-robin pick helper for the lock arbiter
package lock_arbiter_pkg;

    localparam int MAXN = 16;

    typedef enum logic {IDLE, HOLD} lock_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of el scanning ptr, ptr+1, ... modulo n
    function automatic rr_pick_t rr_pick(input logic [MAXN-1:0] el, input logic [3:0] ptr, input int n);
        rr_pick_t   p;
        logic [3:0] j;
        p = '0;
        for (int k = MAXN - 1; k >= 0; k--) begin
            j = 4'((int'(ptr) + k) % n);
            if (k < n && el[j]) begin
                p.valid = 1'b1;
                p.idx   = j;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// lock_sync: one-bit reset-able synchroniser, a plain wire when SYNC_STAGES is 0
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign q = d;
    end else begin : g_flops
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        // shift the raw input in at the bottom of the chain
        always_comb sync_d = SYNC_STAGES'({sync_q, d});
        // chain register, cleared on reset
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= sync_d;
        end
        assign q = sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/lock_arbiter.sv
// lock_arbiter: N-way req/gnt mutex with synchronised inputs, round-robin fairness and lease timeout
module lock_arbiter
    import lock_arbiter_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int TIMEOUT     = 0,
    localparam int OW          = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic [OW-1:0] owner,
    output logic          timeout,
    output logic [OW-1:0] timeout_id
);

    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lock_state_t   state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  stale_q, stale_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [OW-1:0] timeout_id_q, timeout_id_d;
    logic [N-1:0]  rs, el, stale_set;
    logic [OW-1:0] nxt;
    rr_pick_t      pk;

    for (genvar i = 0; i < N; i++) begin : g_sync
        lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req[i]),
            .q   (rs[i])
        );
    end

    assign el = rs & ~stale_q;

    // grant on a round-robin pick; end the hold on release or lease expiry, release winning a tie
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        stale_set    = '0;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        pk           = rr_pick(MAXN'(el), 4'(ptr_q), N);
        nxt          = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
        if (state_q == IDLE) begin
            if (pk.valid) begin
                state_d = HOLD;
                gnt_d   = N'(1) << pk.idx;
                owner_d = OW'(pk.idx);
                cnt_d   = '0;
            end
        end else if (!rs[owner_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            ptr_d   = nxt;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TLIM)) begin
            state_d            = IDLE;
            gnt_d              = '0;
            owner_d            = '0;
            ptr_d              = nxt;
            stale_set[owner_q] = 1'b1;
            timeout_d          = 1'b1;
            timeout_id_d       = owner_q;
        end else if (TIMEOUT != 0 && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        stale_d = (stale_q | stale_set) & rs;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            stale_q      <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            stale_q      <= stale_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = (state_q == HOLD);
    assign owner      = owner_q;
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_lock_arbiter.sv
// tb_lock_arbiter: directed checks of grant latency, round-robin, lease revoke, reset and variants
module tb_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0, req_nt = '0, req_ns = '0;
    logic [3:0] gnt, gnt_nt, gnt_ns;
    logic [1:0] owner, owner_nt, owner_ns, tid, tid_nt, tid_ns;
    logic       busy, busy_nt, busy_ns, tmo, tmo_nt, tmo_ns;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    lock_arbiter #(.N(4), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .busy(busy),
        .owner(owner), .timeout(tmo), .timeout_id(tid)
    );

    lock_arbiter #(.N(4), .SYNC_STAGES(2), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .req(req_nt), .gnt(gnt_nt), .busy(busy_nt),
        .owner(owner_nt), .timeout(tmo_nt), .timeout_id(tid_nt)
    );

    lock_arbiter #(.N(4), .SYNC_STAGES(0), .TIMEOUT(8)) dut_ns (
        .clk(clk), .rst(rst), .req(req_ns), .gnt(gnt_ns), .busy(busy_ns),
        .owner(owner_ns), .timeout(tmo_ns), .timeout_id(tid_ns)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        req_nt = '0;
        req_ns = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic check_main(input string tag, input logic [3:0] g, input logic [1:0] o,
                              input logic t, input logic [1:0] ti);
        check({tag, "_gnt"}, gnt, g);
        check({tag, "_owner"}, owner, o);
        check({tag, "_busy"}, busy, g != 0);
        check({tag, "_timeout"}, tmo, t);
        check({tag, "_tid"}, tid, ti);
    endtask

    initial begin
        int         ord[5] = '{0, 1, 2, 3, 0};
        int         hc[4];
        int         k, zeros;
        logic [3:0] prev, eg;

        // reset state of every instance
        do_reset();
        check_main("reset", 4'b0000, 2'd0, 1'b0, 2'd0);
        check("reset_nt", {gnt_nt, owner_nt, busy_nt, tmo_nt, tid_nt}, 0);
        check("reset_ns", {gnt_ns, owner_ns, busy_ns, tmo_ns, tid_ns}, 0);

        // single channel: grant after 3 cycles, release 3 cycles after drop
        req[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            eg = (c >= 3 && c < 8) ? 4'b0100 : 4'b0000;
            check_main("single", eg, (eg != 0) ? 2'd2 : 2'd0, 1'b0, 2'd0);
            if (c == 5) req[2] = 1'b0;
        end

        // all requesting: round-robin 0,1,2,3,0 with one idle cycle between holders
        do_reset();
        req   = 4'b1111;
        hc    = '{0, 0, 0, 0};
        k     = 0;
        zeros = 0;
        prev  = '0;
        for (int c = 1; c <= 60 && k < 5; c++) begin
            tick();
            check("rr_onehot", $onehot0(gnt), 1);
            if (gnt == 0) zeros++;
            else if (prev == 0) begin
                check("rr_order", gnt, 32'd1 << ord[k]);
                if (k > 0) check("rr_gap", zeros, 1);
                k++;
                zeros = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    hc[i]++;
                    if (hc[i] == 3) req[i] = 1'b0;
                end else if (!req[i]) begin
                    req[i] = 1'b1;
                    hc[i]  = 0;
                end
            end
            prev = gnt;
        end
        check("rr_count", k, 5);

        // fairness: after channel 1 releases, channel 3 beats channel 0
        do_reset();
        req[1] = 1'b1;
        repeat (3) tick();
        check("fair_hold1", gnt, 4'b0010);
        req[0] = 1'b1;
        req[3] = 1'b1;
        tick();
        req[1] = 1'b0;
        repeat (3) tick();
        check("fair_gap", gnt, 4'b0000);
        tick();
        check("fair_gnt3", gnt, 4'b1000);
        check("fair_owner3", owner, 2'd3);

        // lease expiry on channel 1, handover to 0, no regrant until 1 re-requests
        do_reset();
        req[1] = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            eg = (c >= 3 && c <= 10) ? 4'b0010 :
                 (c >= 12 && c <= 14) ? 4'b0001 :
                 (c == 25) ? 4'b0010 : 4'b0000;
            check_main("lease", eg, (eg == 4'b0010) ? 2'd1 : 2'd0, c == 11, (c >= 11) ? 2'd1 : 2'd0);
            if (c == 1)  req[0] = 1'b1;
            if (c == 12) req[0] = 1'b0;
            if (c == 20) req[1] = 1'b0;
            if (c == 22) req[1] = 1'b1;
        end

        // reset pulse mid-hold
        do_reset();
        req[3] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            eg = ((c >= 3 && c <= 5) || c == 9) ? 4'b1000 : 4'b0000;
            check_main("rst_mid", eg, (eg != 0) ? 2'd3 : 2'd0, 1'b0, 2'd0);
            if (c == 5) rst = 1'b1;
            if (c == 6) rst = 1'b0;
        end

        // SYNC_STAGES=0: one-cycle grant and release latency
        do_reset();
        req_ns[0] = 1'b1;
        check("ns_before", gnt_ns, 4'b0000);
        tick();
        check("ns_grant", gnt_ns, 4'b0001);
        req_ns[0] = 1'b0;
        tick();
        check("ns_release", gnt_ns, 4'b0000);

        // TIMEOUT=0: a holder keeps the lock indefinitely
        do_reset();
        req_nt[0] = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            check("nt_gnt", gnt_nt, (c >= 3) ? 4'b0001 : 4'b0000);
            check("nt_timeout", tmo_nt, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
